// File: rtl/sscapture_pkg.sv
// rtl/sscapture_pkg.sv - segment glyph constants and FSM state type for sscapture
package sscapture_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h67;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

endpackage

// File: rtl/sspat2hex.sv
// rtl/sspat2hex.sv - maps a 7-segment pattern {g..a} back to its hex nibble
// Blank counts as valid so callers only need to check valid for errors.
module sspat2hex
   import sscapture_pkg::*;
(
   input  logic [6:0] pat,
   output logic [3:0] nibble,
   output logic       valid,
   output logic       blank
);

   always_comb begin
      nibble = 4'h0;
      valid  = 1'b1;
      blank  = 1'b0;
      case (pat)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/sscapture.sv
// rtl/sscapture.sv - captures a multiplexed 7-segment display bus into a hex frame word
// Each stable digit episode is accepted once; a frame is published when all digits are seen.
module sscapture
   import sscapture_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   blank_mask,
   output logic                    frame_valid,
   output logic                    err_invalid,
   output logic                    err_onehot
);

   localparam logic [7:0]            STABLE_MAX = 8'(STABLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN   = '1;
   localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

   logic [6:0]              samp_seg;
   logic [NUM_DIGITS-1:0]   samp_dig;
   logic [7:0]              stab_cnt;
   state_t                  state, state_nxt;
   logic [4*NUM_DIGITS-1:0] stage_val;
   logic [NUM_DIGITS-1:0]   stage_blank;
   logic [NUM_DIGITS-1:0]   seen;
   logic                    changed;
   logic                    last_stable;
   logic                    accept;
   logic                    dig_onehot;
   logic                    write_ok;
   logic                    frame_done;
   logic [3:0]              pat_nib;
   logic                    pat_valid;
   logic                    pat_blank;

   // Compare the incoming sample against the held one so the counter hits
   // STABLE_CYCLES on the same edge that stores the last identical sample.
   assign changed     = (seg_in != samp_seg) || (dig_sel != samp_dig);
   assign last_stable = !changed && (stab_cnt == STABLE_MAX - 8'd1);
   assign dig_onehot  = (samp_dig != '0) && ((samp_dig & (samp_dig - DIG_ONE)) == '0);
   assign write_ok    = accept && dig_onehot && pat_valid;
   assign frame_done  = (seen == ALL_SEEN);

   sspat2hex u_pat2hex (
      .pat    (samp_seg),
      .nibble (pat_nib),
      .valid  (pat_valid),
      .blank  (pat_blank)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         samp_seg <= '0;
         samp_dig <= '0;
         stab_cnt <= '0;
      end else begin
         samp_seg <= seg_in;
         samp_dig <= dig_sel;
         if (changed)
            stab_cnt <= 8'd1;
         else if (stab_cnt != STABLE_MAX)
            stab_cnt <= stab_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (changed)
         state_nxt = (dig_sel == '0) ? IDLE : SETTLE;
      else if (state == SETTLE && last_stable)
         state_nxt = HELD;
   end

   always_comb begin
      accept = (state == SETTLE) && last_stable;
   end

   // Clear takes priority over both accept and publish, but leaves value intact.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stage_val   <= '0;
         stage_blank <= '0;
         seen        <= '0;
         value       <= '0;
         blank_mask  <= '0;
         frame_valid <= 1'b0;
         err_invalid <= 1'b0;
         err_onehot  <= 1'b0;
      end else if (clear) begin
         stage_val   <= '0;
         stage_blank <= '0;
         seen        <= '0;
         frame_valid <= 1'b0;
         err_invalid <= 1'b0;
         err_onehot  <= 1'b0;
      end else begin
         frame_valid <= frame_done;
         if (frame_done) begin
            value      <= stage_val;
            blank_mask <= stage_blank;
         end
         if (accept && !dig_onehot)
            err_onehot <= 1'b1;
         if (accept && dig_onehot && !pat_valid)
            err_invalid <= 1'b1;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (write_ok && samp_dig[i]) begin
               stage_val[4*i +: 4] <= pat_nib;
               stage_blank[i]      <= pat_blank;
            end
         end
         seen <= (frame_done ? '0 : seen) | (write_ok ? samp_dig : '0);
      end
   end

endmodule

// File: doc/sscapture.md
# sscapture

Capture block for a time-multiplexed 7-segment display bus. It samples the segment lines and the one-hot digit-select lines, waits for each digit to be stable, and decodes each segment pattern back to its hex nibble. It assembles a full multi-digit frame and presents it as a word. It sits on the observation side of the display path, so debug logic and testbenches can read back what the hex display is showing.

## Interface
- `NUM_DIGITS`, default 8: number of multiplexed digits. Legal range 1..8.
- `STABLE_CYCLES`, default 4: number of consecutive identical samples needed before a digit is accepted. Legal range 2..255.

- `clk` input 1: single clock.
- `nrst` input 1: reset, asynchronous, active-low.
- `seg_in` input 7: segment lines, bit order {g,f,e,d,c,b,a}, active-high.
- `dig_sel` input NUM_DIGITS: one-hot digit select. Bit i selects digit i.
- `clear` input 1: synchronous clear of staging, seen mask and error flags.
- `value` output 4*NUM_DIGITS: last completed frame. Digit i is in bits [4i+3:4i].
- `blank_mask` output NUM_DIGITS: bit i is 1 if digit i was blank in the last frame.
- `frame_valid` output 1: one-cycle pulse when `value` and `blank_mask` update.
- `err_invalid` output 1: sticky. Set when an accepted pattern is neither a hex glyph nor blank.
- `err_onehot` output 1: sticky. Set when a stable `dig_sel` has more than one bit set.

## Operation
- Reset values: all outputs 0, staging 0, seen mask 0, FSM in IDLE, stability counter 0.
- Decode table (hex 0..F): 3F 06 5B 4F 66 6D 7D 07 7F 67 77 7C 39 5E 79 71. Pattern 00 means blank: nibble 0, blank bit 1. Any other pattern is invalid.
- Sample register: captures {seg_in, dig_sel} every cycle.
- Stability counter:
  - Reset to 1 when the new sample differs from the held sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: dig_sel == 0. Stays here while dig_sel is 0. Goes to SETTLE on a nonzero sample.
  - SETTLE: counting. On counter reaching STABLE_CYCLES, performs the accept action and goes to HELD. On a sample change, restarts in SETTLE, or goes to IDLE if the new dig_sel is 0.
  - HELD: digit already accepted. No re-accept while the sample is unchanged. On a change, goes to SETTLE or IDLE.
- Accept action, exactly one per stable episode:
  - dig_sel not one-hot: set err_onehot. Nothing is written.
  - Pattern invalid: set err_invalid. Staging is not written and the seen bit is not set.
  - Otherwise: write the nibble and blank bit for digit i into staging and set seen[i]. Re-accepting a digit already seen overwrites its staging entry (latest wins).
- Frame completion: when the seen mask becomes all ones, on the next edge:
  - staging is copied to `value`/`blank_mask`;
  - frame_valid is 1 for that cycle;
  - the seen mask clears.
- `value` and `blank_mask` change only at frame completion. They never show a partial frame.
- `clear`:
  - clears staging, seen mask, err_invalid and err_onehot;
  - does not touch `value`/`blank_mask`;
  - wins over a simultaneous accept or frame completion, in which case no frame_valid is produced;
  - leaves the FSM and counter running.

## Timing
- Input first sampled at edge E and held constant: the accept happens at edge E+STABLE_CYCLES-1 (staging and error flags update there).
- If that accept completes the frame: `value`, `blank_mask` and the frame_valid pulse appear at edge E+STABLE_CYCLES.
- Glitch shorter than STABLE_CYCLES samples: no accept and no flag change.
- Error flags: rise in the same cycle as the accept and stay set until `clear` or reset.
- nrst asserted mid-frame: all state returns to reset values immediately. A partial frame is discarded.
- Back-to-back digits with no blank gap are supported. The minimum digit dwell for capture is STABLE_CYCLES cycles.

## Structure
- `sscapture_pkg` holds:
  - segment constants SEG_0..SEG_F and SEG_BLANK;
  - the FSM state enum {IDLE, SETTLE, HELD}.
- Sub-module `sspat2hex`: combinational, maps a pattern to {nibble, valid, blank}. It is the exact inverse of the display decoder table. The stability logic, FSM, staging and frame logic live in `sscapture`.

## Test plan
- Clean frame (NUM_DIGITS=4, STABLE_CYCLES=4): digits 0..3 show patterns 4F, 5B, 06, 3F, 8 cycles each. Expect value=16'h1234... no: expect value=16'h0123 read as digit3..digit0, blank_mask=0, one frame_valid pulse 1 cycle after digit 3 is accepted.
- Blank and hex letters: digits show 77, 00, 5E, 71. Expect value nibbles {F,D,0,A} for digit3..digit0, blank_mask=4'b0010.
- Glitch rejection: a 3-cycle 7F pulse on digit 0, then a stable 06. Expect digit 0 = 1, no err flags.
- Invalid pattern 0x01 held stable: err_invalid=1, the frame never completes. After `clear` and a valid digit 0, the frame completes.
- dig_sel=4'b0101 held stable: err_onehot=1, staging unchanged.
- Reset mid-frame: nrst low after 2 of 4 digits are accepted. Outputs are 0 immediately, and the next full frame is needed before frame_valid.
